// File: rtl/id_disp_pkg.sv
// Shared constants, FSM state encoding and width helper for the ID display path.
package id_disp_pkg;

  localparam int N_ID_DIG = 16;
  localparam int N_AN     = 8;
  localparam logic [N_AN-1:0] AN_OFF = 8'hFF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  // Bits needed to count 0..v-1; never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (((v - 1) >> i) != 0) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/id_scroll_scan_ctrl_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, synchronous clear holds it at 0.
module tick_gen
  import id_disp_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk100M,
  input  logic sys_rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // A clear in the tick cycle suppresses the tick as well as the count.
  always_comb begin
    tick  = (cnt_q == LAST) && !clr;
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk100M or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/id_scroll_scan_ctrl.sv
// Digit scan and ID window scroll controller for the 8-digit common-anode display.
module id_scroll_scan_ctrl
  import id_disp_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1_000,
  parameter int SCROLL_HZ = 1
) (
  input  logic            clk100M,
  input  logic            sys_rst_n,
  input  logic            en,
  input  logic            U_D,
  input  logic            hold,
  input  logic            step,
  input  logic            dp_in,
  output logic [3:0]      slice_idx,
  output logic [N_AN-1:0] AN,
  output logic            DP,
  output logic [3:0]      scroll_pos,
  output logic            frame_done
);

  localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
  localparam int SCROLL_DIV = CLK_HZ / SCROLL_HZ;
  localparam int PW         = clog2(N_ID_DIG);

  state_e          state_q, state_d;
  logic [2:0]      p_q, p_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [3:0]      slice_q, slice_d;
  logic [N_AN-1:0] an_q, an_d;
  logic            dp_q, dp_d;
  logic            fd_q, fd_d;
  logic            scan_tick, scroll_tick;
  logic            blank, shift_en;

  // Prescaler clears follow the next state so a falling en or a rising hold
  // cancels any tick landing in the same cycle.
  assign blank = (state_d == ST_BLANK);

  tick_gen #(.DIV(SCAN_DIV)) u_scan_div (
    .clk100M   (clk100M),
    .sys_rst_n (sys_rst_n),
    .clr       (blank),
    .tick      (scan_tick)
  );

  tick_gen #(.DIV(SCROLL_DIV)) u_scroll_div (
    .clk100M   (clk100M),
    .sys_rst_n (sys_rst_n),
    .clr       (state_d != ST_RUN),
    .tick      (scroll_tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   state_d = !en ? ST_BLANK : (hold ? ST_HOLD : ST_RUN);
      ST_HOLD:  state_d = !en ? ST_BLANK : (hold ? ST_HOLD : ST_RUN);
      ST_BLANK: state_d = !en ? ST_BLANK : (hold ? ST_HOLD : ST_RUN);
      default:  state_d = ST_BLANK;
    endcase
  end

  always_comb begin
    // Steps count only when already in HOLD and staying there.
    shift_en = scroll_tick || (step && (state_q == ST_HOLD) && (state_d == ST_HOLD));
    pos_d    = pos_q;
    if (shift_en) pos_d = U_D ? pos_q + 1'b1 : pos_q - 1'b1;

    p_d = p_q;
    if (blank)          p_d = 3'd0;
    else if (scan_tick) p_d = p_q + 1'b1;

    fd_d    = scan_tick && (p_q == 3'd7);
    slice_d = pos_d + {1'b0, 3'd7 - p_d};
    an_d    = blank ? AN_OFF : ~(N_AN'(1) << p_d);
    dp_d    = !(!blank && !dp_in && (slice_d == 4'd0));
  end

  always_ff @(posedge clk100M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_RUN;
      p_q     <= 3'd0;
      pos_q   <= '0;
      slice_q <= 4'd7;
      an_q    <= 8'hFE;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      pos_q   <= pos_d;
      slice_q <= slice_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
      fd_q    <= fd_d;
    end
  end

  assign slice_idx  = slice_q;
  assign AN         = an_q;
  assign DP         = dp_q;
  assign scroll_pos = pos_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_id_scroll_scan_ctrl.sv
// Directed bench for id_scroll_scan_ctrl at SCAN_DIV=10, SCROLL_DIV=100.
module tb_id_scroll_scan_ctrl;

  logic       clk100M = 1'b0;
  logic       sys_rst_n;
  logic       en, U_D, hold, step, dp_in;
  logic [3:0] slice_idx, scroll_pos;
  logic [7:0] AN;
  logic       DP, frame_done;

  int checks = 0;
  int errors = 0;
  int n;

  id_scroll_scan_ctrl #(
    .CLK_HZ    (1000),
    .SCAN_HZ   (100),
    .SCROLL_HZ (10)
  ) dut (
    .clk100M    (clk100M),
    .sys_rst_n  (sys_rst_n),
    .en         (en),
    .U_D        (U_D),
    .hold       (hold),
    .step       (step),
    .dp_in      (dp_in),
    .slice_idx  (slice_idx),
    .AN         (AN),
    .DP         (DP),
    .scroll_pos (scroll_pos),
    .frame_done (frame_done)
  );

  always #5 clk100M = ~clk100M;

  task automatic adv(input int cycles);
    repeat (cycles) @(posedge clk100M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-14s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    en = 1'b1; hold = 1'b0; U_D = 1'b1; step = 1'b0; dp_in = 1'b1;
    adv(2);
    chk("rst_an",     AN,         8'hFE);
    chk("rst_slice",  slice_idx,  4'd7);
    chk("rst_dp",     DP,         1'b1);
    chk("rst_fd",     frame_done, 1'b0);
    chk("rst_pos",    scroll_pos, 4'd0);
    sys_rst_n = 1'b1;

    // Scan: edges counted from reset release
    adv(9);   chk("e9_an",      AN,         8'hFE);
    adv(1);   chk("e10_an",     AN,         8'hFD);
              chk("e10_slice",  slice_idx,  4'd6);
    adv(69);  chk("e79_an",     AN,         8'h7F);
              chk("e79_slice",  slice_idx,  4'd0);
              chk("e79_dp",     DP,         1'b1);
              chk("e79_fd",     frame_done, 1'b0);
    adv(1);   chk("e80_fd",     frame_done, 1'b1);
              chk("e80_an",     AN,         8'hFE);
              chk("e80_slice",  slice_idx,  4'd7);
    adv(1);   chk("e81_fd",     frame_done, 1'b0);

    // Scroll in RUN
    adv(18);  chk("e99_pos",    scroll_pos, 4'd0);
    adv(1);   chk("e100_pos",   scroll_pos, 4'd1);
              chk("e100_an",    AN,         8'hFB);
              chk("e100_slice", slice_idx,  4'd6);
    adv(50);  chk("e150_an",    AN,         8'h7F);
              chk("e150_slice", slice_idx,  4'd1);
    adv(1449); chk("e1599_pos", scroll_pos, 4'd15);
    adv(1);   chk("e1600_pos",  scroll_pos, 4'd0);
              chk("e1600_slc",  slice_idx,  4'd7);
    U_D = 1'b0;
    adv(99);  chk("e1699_pos",  scroll_pos, 4'd0);
    adv(1);   chk("e1700_pos",  scroll_pos, 4'd15);
              chk("e1700_slc",  slice_idx,  4'd4);

    // HOLD: scroll frozen, scan running, steps honoured
    hold = 1'b1;
    adv(500); chk("hold_pos",   scroll_pos, 4'd15);
              chk("hold_an",    AN,         8'hEF);
              chk("hold_slice", slice_idx,  4'd2);
    step = 1'b1; adv(1); step = 1'b0;
              chk("step1_pos",  scroll_pos, 4'd14);
    adv(1);
    step = 1'b1; adv(1); step = 1'b0;
              chk("step2_pos",  scroll_pos, 4'd13);

    // Release hold, measure distance to next shift; a step mid-way must be ignored
    hold = 1'b0;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      step = (i == 50);
      adv(1);
      if (scroll_pos !== 4'd13) begin
        n = i;
        break;
      end
    end
    step = 1'b0;
    chk("release_clks", n,          100);
    chk("release_pos",  scroll_pos, 4'd12);

    // Blank mid-scan at p=5
    adv(69);  chk("pre_blank_an", AN,       8'hDF);
    en = 1'b0;
    adv(1);   chk("blank_an",   AN,         8'hFF);
              chk("blank_dp",   DP,         1'b1);
    adv(5);   chk("blank_an2",  AN,         8'hFF);
              chk("blank_pos",  scroll_pos, 4'd12);
    en = 1'b1;
    adv(1);   chk("unblank_an", AN,         8'hFE);
              chk("unblank_slc", slice_idx, 4'd3);
              chk("unblank_pos", scroll_pos, 4'd12);
    adv(8);   chk("p0_hold_an", AN,         8'hFE);
    adv(1);   chk("p1_an",      AN,         8'hFD);

    // Step up to position 0 in HOLD, then decimal point marks ID start
    hold = 1'b1; U_D = 1'b1;
    adv(1);
    for (int i = 0; i < 4; i++) begin
      step = 1'b1; adv(1);
      step = 1'b0; adv(1);
    end
    chk("wrap_up_pos", scroll_pos, 4'd0);
    dp_in = 1'b0;
    adv(50);  chk("dp_p6_an",   AN,         8'hBF);
              chk("dp_p6_dp",   DP,         1'b1);
    adv(1);   chk("dp_p7_an",   AN,         8'h7F);
              chk("dp_p7_slc",  slice_idx,  4'd0);
              chk("dp_p7_dp",   DP,         1'b0);
    adv(9);   chk("dp_p7_dp2",  DP,         1'b0);
    adv(1);   chk("dp_p0_an",   AN,         8'hFE);
              chk("dp_p0_dp",   DP,         1'b1);

    // Asynchronous reset mid-frame
    step = 1'b1; adv(1); step = 1'b0;
    adv(19);  chk("pre_rst_an", AN,         8'hFB);
              chk("pre_rst_slc", slice_idx, 4'd6);
              chk("pre_rst_pos", scroll_pos, 4'd1);
    sys_rst_n = 1'b0;
    #2;
    chk("arst_an",    AN,         8'hFE);
    chk("arst_slice", slice_idx,  4'd7);
    chk("arst_dp",    DP,         1'b1);
    chk("arst_pos",   scroll_pos, 4'd0);
    chk("arst_fd",    frame_done, 1'b0);
    sys_rst_n = 1'b1;
    adv(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
